// File: rtl/dcache_dm_wt.sv
// Direct-mapped write-through, no-write-allocate data cache, one 32-bit word per line.
// Latency: load hit 1 cycle (op_valid_ctrl the cycle after accept); misses/stores wait on ip_mem_ack.
// Backpressure: op_busy=1 outside IDLE and ip_req is ignored then. Optional stats via `DCACHE_STATS_EN.
module dcache_dm_wt #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              ip_clk,
  input  logic              ip_rst,
  input  logic              ip_req,
  input  logic              ip_store_en,
  input  logic [ADDR_W-1:0] ip_load_store_addr,
  input  logic [31:0]       ip_store_data,
  input  logic [1:0]        ip_load_store_bit_ctrl,
  input  logic              ip_load_sign_ctrl,
  input  logic              ip_flush,
  output logic [31:0]       op_data,
  output logic              op_valid_ctrl,
  output logic              op_misalign,
  output logic              op_busy,
  output logic              op_mem_req,
  output logic              op_mem_we,
  output logic [ADDR_W-1:0] op_mem_addr,
  output logic [31:0]       op_mem_wdata,
  output logic [3:0]        op_mem_be,
  input  logic              ip_mem_ack,
  input  logic [31:0]       ip_mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       op_hit_cnt,
  output logic [31:0]       op_miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_RESP, S_FLUSH} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [31:0]        data_arr [LINES];

  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         lane_q;
  logic [1:0]         ctrl_q;
  logic               zext_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        resp_q;
  logic               misalign_q;
  logic [INDEX_W-1:0] flush_cnt_q;

  logic [INDEX_W-1:0] idx_in, idx_q;
  logic [TAG_W-1:0]   tag_in, tag_q;
  logic               is_byte, is_half, misalign_in, hit_in, accept, acc_ok;
  logic [3:0]         be_in;
  logic [31:0]        wdata_in;

  // Pull a byte/half/word out of a memory word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] ctrl, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (ctrl)
      2'b00:   extract = zext ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   extract = zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace the enabled byte lanes of old with those of wd.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction

  assign idx_in  = ip_load_store_addr[INDEX_W+1:2];
  assign tag_in  = ip_load_store_addr[ADDR_W-1:INDEX_W+2];
  assign idx_q   = addr_q[INDEX_W+1:2];
  assign tag_q   = addr_q[ADDR_W-1:INDEX_W+2];
  assign is_byte = (ip_load_store_bit_ctrl == 2'b00);
  assign is_half = (ip_load_store_bit_ctrl == 2'b01);

  // Request decode: alignment, lookup, lane enables and shifted store data.
  always_comb begin
    misalign_in = (is_half && ip_load_store_addr[0]) ||
                  (!is_byte && !is_half && (ip_load_store_addr[1:0] != 2'b00));
    hit_in      = valid_q[idx_in] && (tag_arr[idx_in] == tag_in);
    accept      = (state_q == S_IDLE) && !ip_flush && ip_req;
    acc_ok      = accept && !misalign_in;
    if (is_byte) begin
      be_in    = 4'b0001 << ip_load_store_addr[1:0];
      wdata_in = {24'b0, ip_store_data[7:0]} << {ip_load_store_addr[1:0], 3'b000};
    end else if (is_half) begin
      be_in    = 4'b0011 << {ip_load_store_addr[1], 1'b0};
      wdata_in = {16'b0, ip_store_data[15:0]} << {ip_load_store_addr[1], 4'b0000};
    end else begin
      be_in    = 4'hF;
      wdata_in = ip_store_data;
    end
  end

  // State register.
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and all outputs; memory-side outputs are combinational from state so reset drops them at once.
  always_comb begin
    state_d       = state_q;
    op_busy       = 1'b1;
    op_mem_req    = 1'b0;
    op_mem_we     = 1'b0;
    op_mem_be     = 4'h0;
    op_valid_ctrl = 1'b0;
    op_data       = 32'h0;
    op_misalign   = misalign_q;
    op_mem_addr   = addr_q;
    op_mem_wdata  = wdata_q;
    case (state_q)
      S_IDLE: begin
        op_busy = 1'b0;
        if (ip_flush)    state_d = S_FLUSH;
        else if (acc_ok) state_d = ip_store_en ? S_WRITE : (hit_in ? S_RESP : S_FILL);
      end
      S_FILL: begin
        op_mem_req = 1'b1;
        op_mem_be  = 4'hF;
        if (ip_mem_ack) state_d = S_RESP;
      end
      S_WRITE: begin
        op_mem_req = 1'b1;
        op_mem_we  = 1'b1;
        op_mem_be  = be_q;
        if (ip_mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        op_valid_ctrl = 1'b1;
        op_data       = resp_q;
        state_d       = S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt_q == {INDEX_W{1'b1}}) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, response data, misalign pulse and flush index.
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      addr_q      <= '0;
      lane_q      <= 2'b00;
      ctrl_q      <= 2'b00;
      zext_q      <= 1'b0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      resp_q      <= 32'h0;
      misalign_q  <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      misalign_q <= accept && misalign_in;
      if (acc_ok) begin
        addr_q  <= {ip_load_store_addr[ADDR_W-1:2], 2'b00};
        lane_q  <= ip_load_store_addr[1:0];
        ctrl_q  <= ip_load_store_bit_ctrl;
        zext_q  <= ip_load_sign_ctrl;
        wdata_q <= wdata_in;
        be_q    <= be_in;
        resp_q  <= ip_store_en ? 32'h0
                               : extract(data_arr[idx_in], ip_load_store_addr[1:0],
                                         ip_load_store_bit_ctrl, ip_load_sign_ctrl);
      end
      if (state_q == S_FILL && ip_mem_ack)
        resp_q <= extract(ip_mem_rdata, lane_q, ctrl_q, zext_q);
      if (state_q == S_IDLE && ip_flush)
        flush_cnt_q <= '0;
      else if (state_q == S_FLUSH)
        flush_cnt_q <= flush_cnt_q + {{(INDEX_W-1){1'b0}}, 1'b1};
    end
  end

  // Valid bits: set on refill, cleared one line per cycle while flushing.
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      valid_q <= '0;
    end else begin
      if (state_q == S_FILL && ip_mem_ack) valid_q[idx_q] <= 1'b1;
      if (state_q == S_FLUSH)              valid_q[flush_cnt_q] <= 1'b0;
    end
  end

  // Tag/data arrays (not reset): store-hit merge at accept, refill on ack.
  always_ff @(posedge ip_clk) begin
    if (acc_ok && ip_store_en && hit_in)
      data_arr[idx_in] <= merge(data_arr[idx_in], wdata_in, be_in);
    if (state_q == S_FILL && ip_mem_ack) begin
      data_arr[idx_q] <= ip_mem_rdata;
      tag_arr[idx_q]  <= tag_q;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters for accepted aligned loads; cleared when a flush starts.
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      op_hit_cnt  <= 32'h0;
      op_miss_cnt <= 32'h0;
    end else if (state_q == S_IDLE && ip_flush) begin
      op_hit_cnt  <= 32'h0;
      op_miss_cnt <= 32'h0;
    end else if (acc_ok && !ip_store_en) begin
      if (hit_in && op_hit_cnt != 32'hFFFF_FFFF)   op_hit_cnt  <= op_hit_cnt + 32'd1;
      if (!hit_in && op_miss_cnt != 32'hFFFF_FFFF) op_miss_cnt <= op_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Bench for dcache_dm_wt: directed scenarios plus random loads/stores/flushes against a
// word-level model of the cache contents and backing memory.
module tb_dcache_dm_wt;

  logic        clk = 1'b0;
  logic        rst, req, st_en, sign_ctrl, flush, mem_ack;
  logic [31:0] addr, st_data, mem_rdata;
  logic [1:0]  bit_ctrl;
  logic [31:0] data, mem_addr, mem_wdata;
  logic        valid, misalign, busy, mem_req, mem_we;
  logic [3:0]  mem_be;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: line valid/tag/data by index, and memory words by word address.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] mem     [logic [31:0]];

  always #5 clk = ~clk;

  dcache_dm_wt #(.ADDR_W(32), .INDEX_W(6)) dut (
    .ip_clk(clk), .ip_rst(rst), .ip_req(req), .ip_store_en(st_en),
    .ip_load_store_addr(addr), .ip_store_data(st_data),
    .ip_load_store_bit_ctrl(bit_ctrl), .ip_load_sign_ctrl(sign_ctrl), .ip_flush(flush),
    .op_data(data), .op_valid_ctrl(valid), .op_misalign(misalign), .op_busy(busy),
    .op_mem_req(mem_req), .op_mem_we(mem_we), .op_mem_addr(mem_addr),
    .op_mem_wdata(mem_wdata), .op_mem_be(mem_be), .ip_mem_ack(mem_ack),
    .ip_mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .op_hit_cnt(hit_cnt), .op_miss_cnt(miss_cnt)
`endif
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Expected load result: shift the addressed field down, mask to size, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] c, input bit z);
    int nb, sh;
    longint unsigned v, m;
    nb = (c == 2'd0) ? 8 : (c == 2'd1) ? 16 : 32;
    sh = (c == 2'd0) ? 8 * int'(a) : (c == 2'd1) ? 16 * int'(a[1]) : 0;
    v  = {32'b0, w} >> sh;
    m  = (64'd1 << nb) - 64'd1;
    v  = v & m;
    if (!z && v[nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // Byte range a store touches: first byte and byte count.
  function automatic int st_first(input logic [31:0] a, input logic [1:0] c);
    return (c == 2'd0) ? int'(a[1:0]) : (c == 2'd1) ? 2 * int'(a[1]) : 0;
  endfunction
  function automatic int st_count(input logic [1:0] c);
    return (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : 4;
  endfunction

  task automatic idle_inputs();
    req = 1'b0; st_en = 1'b0; addr = 32'h0; st_data = 32'h0; bit_ctrl = 2'b10;
    sign_ctrl = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  // One CPU access from IDLE, starting and ending at a falling edge. dly<0 = random ack delay.
  task automatic do_access(input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] c, input bit z, input int dly,
                           output logic [31:0] got);
    bit          misal, hit;
    int          idx, f, n, wait_n;
    logic [31:0] wa, exp_be, exp_wd, exp_data, rd, newword;
    logic [3:0]  be4;
    misal = (c == 2'd1 && a[0]) || (c[1] && a[1:0] != 2'b00);
    idx   = int'(a[7:2]);
    hit   = m_valid[idx] && (m_tag[idx] == a[31:8]);
    wa    = {a[31:2], 2'b00};
    got   = 32'h0;
    req = 1'b1; st_en = st; addr = a; st_data = d; bit_ctrl = c; sign_ctrl = z;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    if (misal) begin
      total++; if (misalign !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || valid !== 1'b0) begin
        bad++; $display("FAIL misalign_pulse a=%h: mis=%b busy=%b req=%b vld=%b want 1 0 0 0", a, misalign, busy, mem_req, valid); end
      @(posedge clk); @(negedge clk);
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL misalign_one_cycle: got %b want 0", misalign); end
      return;
    end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL misalign_spurious a=%h: got %b want 0", a, misalign); end
    if (!st && hit) begin
      exp_data = ref_load(m_data[idx], a[1:0], c, z);
      got = data;
      total++; if (valid !== 1'b1 || mem_req !== 1'b0 || data !== exp_data) begin
        bad++; $display("FAIL load_hit a=%h: vld=%b req=%b data=%h want 1 0 %h", a, valid, mem_req, data, exp_data); end
    end else begin
      f = st_first(a, c); n = st_count(c);
      be4 = 4'h0; exp_wd = 32'h0;
      for (int i = 0; i < n; i++) begin
        be4[f+i] = 1'b1;
        exp_wd[8*(f+i) +: 8] = d[8*i +: 8];
      end
      exp_be = st ? {28'b0, be4} : 32'hF;
      total++; if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== wa || {28'b0, mem_be} !== exp_be) begin
        bad++; $display("FAIL mem_request a=%h: req=%b we=%b addr=%h be=%h want 1 %b %h %h", a, mem_req, mem_we, mem_addr, mem_be, st, wa, exp_be[3:0]); end
      if (st) begin
        total++; if (mem_wdata !== exp_wd) begin bad++; $display("FAIL mem_wdata a=%h: got %h want %h", a, mem_wdata, exp_wd); end
      end
      wait_n = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int k = 0; k < wait_n; k++) begin
        req = $urandom_range(0, 1); st_en = $urandom_range(0, 1);
        addr = 32'h7000 | ($urandom & 32'hFC); st_data = $urandom;
        @(posedge clk); @(negedge clk);
        total++; if (mem_req !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL mem_req_held a=%h: req=%b busy=%b want 1 1", a, mem_req, busy); end
      end
      req = 1'b0;
      rd = st ? $urandom : mem_rd(wa);
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      exp_data = st ? 32'h0 : ref_load(rd, a[1:0], c, z);
      got = data;
      total++; if (valid !== 1'b1 || data !== exp_data || mem_req !== 1'b0) begin
        bad++; $display("FAIL response a=%h: vld=%b data=%h req=%b want 1 %h 0", a, valid, data, mem_req, exp_data); end
      if (st) begin
        newword = mem_rd(wa);
        for (int i = 0; i < n; i++) newword[8*(f+i) +: 8] = d[8*i +: 8];
        mem[wa] = newword;
        if (hit) m_data[idx] = newword;
      end else begin
        m_valid[idx] = 1'b1; m_tag[idx] = a[31:8]; m_data[idx] = rd;
      end
    end
    @(posedge clk); @(negedge clk);
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL back_to_idle a=%h: busy=%b vld=%b want 0 0", a, busy, valid); end
  endtask

  // Flush (optionally with a simultaneous request that must lose); expects 64 busy cycles.
  task automatic do_flush(input bit with_req);
    int busy_n, stray;
    flush = 1'b1; req = with_req; st_en = 1'b0; addr = 32'h4010; bit_ctrl = 2'b10;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; req = 1'b0;
    busy_n = 0; stray = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) busy_n++;
      if (valid || mem_req || misalign) stray++;
      @(posedge clk); @(negedge clk);
    end
    total++; if (busy_n != 64 || stray != 0) begin
      bad++; $display("FAIL flush_busy: busy_cycles=%0d stray=%0d want 64 0", busy_n, stray); end
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] g;
    idle_inputs();
    rst = 1'b1;
    #1;
    total++; if (data !== 0 || valid !== 0 || misalign !== 0 || busy !== 0 || mem_req !== 0 ||
                 mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_be !== 0) begin
      bad++; $display("FAIL reset_outputs: data=%h vld=%b mis=%b busy=%b req=%b we=%b addr=%h wd=%h be=%h want all 0",
                      data, valid, misalign, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    do_access(1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 1, g);
    req = 1'b1; st_en = 1'b0; addr = 32'h4100; bit_ctrl = 2'b10;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fill_started: got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_aborts_fill: req=%b busy=%b want 0 0", mem_req, busy); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    do_access(1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 0, g);
  endtask

  task automatic test_miss_hit();
    logic [31:0] g;
    mem[32'h4010] = 32'h1234_5678;
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 3, g);
    total++; if (g !== 32'h1234_5678) begin bad++; $display("FAIL lw_miss_data: got %h want 12345678", g); end
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
    total++; if (g !== 32'h1234_5678) begin bad++; $display("FAIL lw_hit_data: got %h want 12345678", g); end
  endtask

  task automatic test_store_merge();
    logic [31:0] g;
    do_access(1'b1, 32'h4011, 32'h0000_00AB, 2'b00, 1'b0, 1, g);
    do_access(1'b0, 32'h4011, 32'h0, 2'b00, 1'b1, 0, g);
    total++; if (g !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_merged: got %h want 000000ab", g); end
    do_access(1'b0, 32'h4011, 32'h0, 2'b00, 1'b0, 0, g);
    total++; if (g !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_merged: got %h want ffffffab", g); end
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
    total++; if (g !== 32'h1234_AB78) begin bad++; $display("FAIL lw_merged: got %h want 1234ab78", g); end
  endtask

  task automatic test_conflict();
    logic [31:0] g;
    do_access(1'b1, 32'h5010, 32'hCAFE_F00D, 2'b10, 1'b0, 2, g);
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
    total++; if (g !== 32'h1234_AB78) begin bad++; $display("FAIL no_allocate_keeps_line: got %h want 1234ab78", g); end
    do_access(1'b0, 32'h5010, 32'h0, 2'b10, 1'b0, 1, g);
    total++; if (g !== 32'hCAFE_F00D) begin bad++; $display("FAIL refill_written_word: got %h want cafef00d", g); end
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
  endtask

  task automatic test_misalign();
    logic [31:0] g;
    do_access(1'b0, 32'h4001, 32'h0, 2'b01, 1'b0, 0, g);
    do_access(1'b1, 32'h4012, 32'h1111_2222, 2'b11, 1'b0, 0, g);
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
  endtask

  task automatic test_flush();
    logic [31:0] g;
    do_flush(1'b1);
    do_access(1'b0, 32'h4010, 32'h0, 2'b10, 1'b0, 0, g);
  endtask

  task automatic test_random();
    logic [31:0] g, a;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_flush($urandom_range(0, 1));
      end else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h4000;
          1:       a = 32'h5000;
          default: a = 32'h6000;
        endcase
        a = a + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
        do_access($urandom_range(0, 2) == 0, a, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1), -1, g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_store_merge();
    test_conflict();
    test_misalign();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
